cordic_step_ctrl: RTL and testbench
===================================

Name: cordic_step_ctrl

Overview:
Parametrised single-step controller for the iterative CORDIC datapath.
- Turns a raw, bouncing push-button into clean step events.
- Issues iteration indices 0..N_ITER-1 one per button release, plus a one-cycle step strobe and a stop/done status.
- Sits between the board button and the CORDIC iteration core; replaces the combinational, latch-based stepping logic with fully registered state, debounce, a saturating press counter and explicit completion.

Parameters:
N_ITER, 16, number of CORDIC iterations; valid range 2..256
ITER_W, 4, width of iter_idx; must satisfy 2**ITER_W >= N_ITER
DEB_CYCLES, 4, consecutive identical synchronised samples required to change the debounced level (>=1)
AUTO_DIV, 8, cycles between automatic steps when auto-run is compiled in and enabled (>=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
btn  input  1  raw asynchronous push-button, high = pressed
iter_idx  output  ITER_W  current iteration index for the CORDIC core
iter_valid  output  1  one-cycle strobe; iter_idx updated this cycle
stop  output  1  high = CORDIC core must hold; low only in non-final step cycles
done  output  1  high once index N_ITER-1 has been issued; sticky until reset
press_cnt  output  $clog2(N_ITER+1)  accepted presses, saturating at N_ITER
busy  output  1  high while the button is held (ARMED state)
auto_en  input  1  present only with CORDIC_AUTO_RUN_EN; enables timed stepping

Behaviour:
- Reset (reset=1 at posedge clk) values:
  - iter_idx=0, iter_valid=0, stop=1, done=0, press_cnt=0, busy=0.
  - Synchroniser flops and debounce counter are cleared; debounced level=0.
  - State is IDLE.
- Reset wins over every other event. Reset mid-operation aborts the sequence; a button held through reset produces no step until it is released and pressed again.
- Input path:
  - 2-flop synchroniser on btn.
  - Debounced level changes only after DEB_CYCLES consecutive synchronised samples differ from the current level. Any agreeing sample restarts the count.
  - rise = debounced 0->1; fall = debounced 1->0; each is a one-cycle internal pulse.
- Latency: raw btn edge -> debounced edge = 2+DEB_CYCLES cycles. Debounced fall -> iter_valid on the next posedge (registered).
- FSM (registered state, single next-state block, all outputs default-assigned):
  - IDLE:
    - rise -> ARMED, press_cnt=1.
  - ARMED (busy=1):
    - fall -> STEP.
    - rise cannot occur here.
  - STEP (one cycle), iter_valid=1:
    - iter_idx = 0 if press_cnt==1, else iter_idx+1.
    - If the new index is N_ITER-1: stop stays 1, done=1, next state DONE.
    - Otherwise stop=0 for this cycle only, next state HOLD.
  - HOLD:
    - rise -> ARMED, press_cnt+1 (saturating at N_ITER).
  - DONE:
    - All presses are ignored; press_cnt holds; iter_idx holds N_ITER-1.
    - Only reset exits.
- iter_idx never wraps and never exceeds N_ITER-1. press_cnt never exceeds N_ITER.
- Unused state encodings return to IDLE with reset output values.
- Outputs other than iter_valid and stop hold their values between events.

Optional Feature:
CORDIC_AUTO_RUN_EN
- Defined:
  - auto_en port exists, together with a timer that counts 0..AUTO_DIV-1.
  - In HOLD with auto_en=1, the timer runs. At terminal count the FSM enters STEP exactly as if a release had occurred, and press_cnt increments.
  - The timer clears on entry to HOLD, when auto_en=0, and on reset.
  - A button press in HOLD still takes priority and clears the timer.
  - IDLE requires a manual first press.
- Undefined: no auto_en port and no timer; stepping is button-only.

Decomposition:
- Package cordic_ctrl_pkg:
  - state enum (IDLE, ARMED, STEP, HOLD, DONE).
  - Default N_ITER/ITER_W constants.
  - Width function for press_cnt.
- Sub-module btn_debounce (params DEB_CYCLES):
  - Contains the synchroniser and debounce counter.
  - Outputs level, rise and fall.
  - Instantiated once here; reusable for other board buttons.

Test Plan:
1. Assert reset for 3 cycles, btn=0 -> iter_idx=0, stop=1, done=0, press_cnt=0, busy=0, iter_valid never asserted.
2. btn high for 2 cycles then low (glitch shorter than DEB_CYCLES=4) -> no rise, state stays IDLE, press_cnt=0.
3. Clean press of 10 cycles, then release -> busy=1 during hold. iter_valid pulses exactly once, 7 cycles after raw release (2+4+1), with iter_idx=0, stop=0 in that cycle only, press_cnt=1.
4. 16 clean press/release pairs (N_ITER=16) -> indices 0..15 in order. Release 16: iter_valid=1 with stop=1 and done=1 set. Press 17 -> no strobe, press_cnt stays 16, iter_idx stays 15.
5. After 3 steps (iter_idx=2), press and hold; assert reset while ARMED, then release -> no iter_valid, all outputs at reset values. The next press/release gives iter_idx=0.
6. With CORDIC_AUTO_RUN_EN and AUTO_DIV=8: one manual step, then auto_en=1 -> iter_valid every 8 cycles with indices 1..15, then done=1. Dropping auto_en mid-run halts stepping in HOLD with the timer cleared.

Source files
------------

// File: rtl/cordic_ctrl_pkg.sv
// cordic_ctrl_pkg: shared state type, default sizes and width helper
// for the CORDIC single-step controller.
package cordic_ctrl_pkg;

  localparam int N_ITER_DEF = 16;
  localparam int ITER_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    STEP  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int press_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus counting debouncer for a
// raw board button; emits clean level and one-cycle rise/fall pulses.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic s1, s2;
  logic v1, v2;
  logic init, cand;
  logic [CW-1:0] cnt;

  // After reset the true button level is unknown: it is learned silently
  // so a button held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      init  <= 1'b1;
      cand  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      v1   <= 1'b1;
      v2   <= v1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (!v2) begin
        cnt <= '0;
      end else if (init) begin
        if (s2 == cand && cnt == CMAX) begin
          level <= cand;
          init  <= 1'b0;
          cnt   <= '0;
        end else if (s2 == cand) begin
          cnt <= cnt + 1'b1;
        end else if (DEB_CYCLES == 1) begin
          level <= s2;
          init  <= 1'b0;
          cnt   <= '0;
        end else begin
          cand <= s2;
          cnt  <= CW'(1);
        end
      end else if (s2 != level) begin
        if (cnt == CMAX) begin
          level <= s2;
          rise  <= s2;
          fall  <= !s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cordic_step_ctrl.sv
// cordic_step_ctrl: button-driven iteration stepper for the CORDIC core.
// Optional timed auto-stepping is compiled in with CORDIC_AUTO_RUN_EN.
module cordic_step_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int N_ITER     = N_ITER_DEF,
  parameter int ITER_W     = ITER_W_DEF,
  parameter int DEB_CYCLES = 4,
  parameter int AUTO_DIV   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn,
  output logic [ITER_W-1:0]          iter_idx,
  output logic                       iter_valid,
  output logic                       stop,
  output logic                       done,
  output logic [press_w(N_ITER)-1:0] press_cnt,
  output logic                       busy
`ifdef CORDIC_AUTO_RUN_EN
  ,
  input  logic                       auto_en
`endif
);

  localparam int PW = press_w(N_ITER);
  localparam logic [ITER_W-1:0] LAST = ITER_W'(N_ITER - 1);
  localparam logic [PW-1:0] PMAX = PW'(N_ITER);
  localparam logic [PW-1:0] PONE = PW'(1);

  state_t state;
  logic rise, fall, unused_level;
  logic go;
  logic [ITER_W-1:0] nidx;
  logic [PW-1:0] pinc;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .level(unused_level),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    nidx = iter_idx;
    if (state == ARMED && press_cnt == PONE) begin
      nidx = '0;
    end else if (iter_idx != LAST) begin
      nidx = iter_idx + 1'b1;
    end
  end

  assign pinc = (press_cnt == PMAX) ? press_cnt : press_cnt + 1'b1;

`ifdef CORDIC_AUTO_RUN_EN
  localparam int TW = $clog2(AUTO_DIV);
  // The STEP cycle is the last tick of each auto period.
  localparam logic [TW-1:0] TC = TW'(AUTO_DIV - 2);
  logic [TW-1:0] tmr;

  assign go = (state == ARMED && fall) ||
              (state == HOLD && !rise && auto_en && tmr == TC);
`else
  localparam int unused_auto_div = AUTO_DIV;

  assign go = state == ARMED && fall;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      iter_idx   <= '0;
      iter_valid <= 1'b0;
      stop       <= 1'b1;
      done       <= 1'b0;
      press_cnt  <= '0;
      busy       <= 1'b0;
`ifdef CORDIC_AUTO_RUN_EN
      tmr        <= '0;
`endif
    end else begin
      iter_valid <= 1'b0;
      stop       <= 1'b1;
      if (go) begin
        state      <= STEP;
        busy       <= 1'b0;
        iter_valid <= 1'b1;
        iter_idx   <= nidx;
        if (state == HOLD) press_cnt <= pinc;
        if (nidx == LAST) done <= 1'b1;
        else              stop <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state     <= ARMED;
              busy      <= 1'b1;
              press_cnt <= PONE;
            end
          end
          ARMED: ;
          STEP: state <= done ? DONE : HOLD;
          HOLD: begin
            if (rise) begin
              state     <= ARMED;
              busy      <= 1'b1;
              press_cnt <= pinc;
            end
          end
          DONE: ;
          default: begin
            state     <= IDLE;
            iter_idx  <= '0;
            done      <= 1'b0;
            press_cnt <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
`ifdef CORDIC_AUTO_RUN_EN
      if (state == HOLD && !rise && auto_en && !go) tmr <= tmr + 1'b1;
      else                                          tmr <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_cordic_step_ctrl.sv
// tb_cordic_step_ctrl: directed checks of debounce, stepping, completion
// and reset abort for cordic_step_ctrl (N_ITER=16, DEB_CYCLES=4).
module tb_cordic_step_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic [3:0] iter_idx;
  logic       iter_valid, stop, done, busy;
  logic [4:0] press_cnt;
`ifdef CORDIC_AUTO_RUN_EN
  logic       auto_en = 1'b0;
`endif

  int nchk = 0;
  int nerr = 0;
  int nvalid = 0;
  int cyc = 0;
  int q_idx[$];
  int q_stop[$];
  int q_done[$];
  int q_cyc[$];

  always #5 clk = ~clk;

  cordic_step_ctrl #(
    .N_ITER(16), .ITER_W(4), .DEB_CYCLES(4), .AUTO_DIV(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .iter_idx  (iter_idx),
    .iter_valid(iter_valid),
    .stop      (stop),
    .done      (done),
    .press_cnt (press_cnt),
    .busy      (busy)
`ifdef CORDIC_AUTO_RUN_EN
    ,
    .auto_en   (auto_en)
`endif
  );

  // Pre-edge values: records each strobe cycle exactly once.
  always @(posedge clk) begin
    cyc++;
    if (iter_valid) begin
      nvalid++;
      q_idx.push_back(int'(iter_idx));
      q_stop.push_back(int'(stop));
      q_done.push_back(int'(done));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    tick(10);
  endtask

  task automatic press(input int hold);
    btn = 1'b1;
    tick(hold);
    btn = 1'b0;
    tick(12);
  endtask

  initial begin
    int seen;
    int n0;

    // 1: reset state
    @(negedge clk);
    tick(2);
    chk("rst_idx", int'(iter_idx), 0);
    chk("rst_stop", int'(stop), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_pcnt", int'(press_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(iter_valid), 0);
    reset = 1'b0;
    tick(10);
    chk("rst_nostrobe", nvalid, 0);

    // 2: short glitch is filtered
    btn = 1'b1;
    tick(2);
    btn = 1'b0;
    tick(12);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_pcnt", int'(press_cnt), 0);
    chk("glitch_strobe", nvalid, 0);

    // 3: first clean press, release latency 2+4+1
    btn = 1'b1;
    tick(10);
    chk("p1_busy", int'(busy), 1);
    chk("p1_pcnt", int'(press_cnt), 1);
    btn = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (iter_valid) seen = 1;
    end
    chk("p1_early", seen, 0);
    tick(1);
    chk("p1_valid", int'(iter_valid), 1);
    chk("p1_idx", int'(iter_idx), 0);
    chk("p1_stop", int'(stop), 0);
    chk("p1_pcnt2", int'(press_cnt), 1);
    tick(1);
    chk("p1_valid_off", int'(iter_valid), 0);
    chk("p1_stop_off", int'(stop), 1);
    chk("p1_busy_off", int'(busy), 0);
    tick(10);

    // 4: full run of 16 steps, then an ignored press
    for (int k = 1; k < 16; k++) press(10);
    chk("run_count", nvalid, 16);
    for (int k = 0; k < 16 && k < q_idx.size(); k++) begin
      chk($sformatf("run_idx%0d", k), q_idx[k], k);
      chk($sformatf("run_stop%0d", k), q_stop[k], (k == 15) ? 1 : 0);
      chk($sformatf("run_done%0d", k), q_done[k], (k == 15) ? 1 : 0);
    end
    chk("run_pcnt", int'(press_cnt), 16);
    btn = 1'b1;
    tick(10);
    chk("p17_busy", int'(busy), 0);
    btn = 1'b0;
    tick(12);
    chk("p17_count", nvalid, 16);
    chk("p17_pcnt", int'(press_cnt), 16);
    chk("p17_idx", int'(iter_idx), 15);
    chk("p17_done", int'(done), 1);
    chk("p17_stop", int'(stop), 1);

    // 5: reset while ARMED aborts; held button is not a press
    do_reset(2);
    chk("r2_done", int'(done), 0);
    chk("r2_idx", int'(iter_idx), 0);
    for (int k = 0; k < 3; k++) press(10);
    chk("ab_idx", int'(iter_idx), 2);
    btn = 1'b1;
    tick(10);
    chk("ab_busy", int'(busy), 1);
    n0 = nvalid;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    chk("ab_busy_held", int'(busy), 0);
    btn = 1'b0;
    tick(12);
    chk("ab_nostrobe", nvalid, n0);
    chk("ab_idx0", int'(iter_idx), 0);
    chk("ab_pcnt", int'(press_cnt), 0);
    chk("ab_busy0", int'(busy), 0);
    chk("ab_stop", int'(stop), 1);
    chk("ab_done", int'(done), 0);
    press(10);
    chk("ab_next_cnt", nvalid, n0 + 1);
    chk("ab_next_idx", int'(iter_idx), 0);
    chk("ab_next_pcnt", int'(press_cnt), 1);
    if (q_idx.size() > 0) chk("ab_next_q", q_idx[q_idx.size() - 1], 0);

`ifdef CORDIC_AUTO_RUN_EN
    // 6a: auto run to completion after one manual step
    do_reset(2);
    press(10);
    n0 = nvalid;
    auto_en = 1'b1;
    tick(8 * 15 + 10);
    auto_en = 1'b0;
    chk("au_count", nvalid, n0 + 15);
    chk("au_done", int'(done), 1);
    chk("au_pcnt", int'(press_cnt), 16);
    for (int k = 1; k < 16 && n0 + k - 1 < q_idx.size(); k++) begin
      chk($sformatf("au_idx%0d", k), q_idx[n0 + k - 1], k);
      if (k > 1)
        chk($sformatf("au_gap%0d", k),
            q_cyc[n0 + k - 1] - q_cyc[n0 + k - 2], 8);
    end

    // 6b: dropping auto_en halts in HOLD and clears the timer
    do_reset(2);
    press(10);
    n0 = nvalid;
    auto_en = 1'b1;
    tick(20);
    auto_en = 1'b0;
    tick(40);
    chk("ah_count", nvalid, n0 + 2);
    chk("ah_idx", int'(iter_idx), 2);
    auto_en = 1'b1;
    tick(6);
    chk("ah_cleared", nvalid, n0 + 2);
    tick(3);
    chk("ah_resume", nvalid, n0 + 3);
    chk("ah_idx3", int'(iter_idx), 3);
    auto_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
